fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined RV32I core. It holds the PC, presents the fetch address to instruction memory, and captures the returned instruction into the IF/ID register. It sits directly upstream of `hazardunit`: its `instr_id` output feeds the hazard unit, and it consumes the hazard unit's `en` stall output. It also takes taken-branch/jump redirects from EX and handles instruction-memory wait cycles by inserting bubbles.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0013, bubble encoding (`addi x0,x0,0`). Its opcode[6:2] is nonzero, so the hazard unit never treats a bubble as a load.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  from `hazardunit`. 1 = pipeline advances; 0 = load-use stall, hold PC and IF/ID.
- redirect  input  1  taken branch/jump resolved in EX.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and forced to 0.
- imem_addr  output  32  fetch address, equal to the current PC register (combinational from the register).
- imem_rdata  input  32  instruction at imem_addr, valid the same cycle when imem_valid=1.
- imem_valid  input  1  1 = imem_rdata is valid this cycle.
- pc_id  output  32  PC of the instruction in IF/ID.
- pc4_id  output  32  pc_id + 4, used for JAL/JALR link.
- instr_id  output  32  instruction in IF/ID; NOP when empty.
- valid_id  output  1  1 = IF/ID holds a real instruction.

## Operation
- State: PC register `pc`, plus the IF/ID register {pc_id, pc4_id, instr_id, valid_id}.
- Per-cycle update, evaluated in priority order when rst=0:
  1. redirect=1: pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble. This overrides en=0 and imem_valid=0; the wrong-path instruction is discarded.
  2. en=0: pc holds; IF/ID holds all fields unchanged, including the NOP or valid state.
  3. imem_valid=0: pc holds; IF/ID <= bubble.
  4. Otherwise: pc <= pc+4; IF/ID <= {pc, pc+4, imem_rdata, 1}.
- Bubble is defined as {pc_id unchanged, pc4_id unchanged, instr_id=NOP, valid_id=0}.
- All PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- imem_addr[1:0] is always 2'b00, because neither the reset path nor the redirect path can produce a misaligned PC.
- No combinational path from en, redirect or imem_valid to any output. imem_addr depends only on `pc`.

## Timing
- Reset (rst=1 at an edge): pc=RESET_PC, pc_id=0, pc4_id=0, instr_id=NOP, valid_id=0. imem_addr=RESET_PC in the first cycle after reset.
- Fetch-to-ID latency: 1 cycle. The instruction presented at imem_addr in cycle N appears on instr_id in cycle N+1.
- Redirect asserted in cycle N:
  - imem_addr=target in N+1.
  - instr_id=NOP in N+1.
  - Target instruction appears on instr_id in N+2.
- Load-use stall: en=0 for one cycle holds instr_id and pc for exactly that cycle. The ID-stage instruction is re-presented to the hazard unit, and downstream ID/EX takes the hazard unit's flush.
- Memory wait of k cycles (imem_valid=0): k bubbles enter IF/ID, and the PC advances only on the first valid cycle.
- Simultaneous events: redirect with en=0 → the redirect is applied. en=0 with imem_valid=0 → hold, with no bubble inserted.
- rst asserted mid-stream overrides every input on that edge.

## Test plan
- Reset then straight-line fetch, imem_valid=1, en=1:
  - instr_id sequence is NOP, mem[0], mem[4], mem[8].
  - pc_id sequence is 0, 0, 4, 8.
  - pc4_id = pc_id + 4 once valid_id=1.
- Load-use stall (en=0 in the cycle instr_id=mem[8]):
  - instr_id stays mem[8] for 2 cycles.
  - imem_addr stays 12 for 2 cycles.
  - The next cycle instr_id=mem[12].
- Redirect to 32'h0000_0103 in cycle N:
  - N+1: imem_addr=32'h0000_0100, instr_id=NOP, valid_id=0.
  - N+2: instr_id=mem[0x100], pc_id=32'h100.
- imem_valid low for 3 cycles at PC=0x20:
  - Three NOP/valid_id=0 entries appear in IF/ID.
  - Then mem[0x20] appears, with pc_id=0x20.
- Simultaneous events:
  - redirect=1 with en=0: the redirect is taken (imem_addr=target next cycle, instr_id=NOP).
  - en=0 with imem_valid=0: IF/ID is held and not bubbled.
- Wrap-around and reset:
  - PC reaching 0xFFFFFFFC wraps to 0.
  - rst asserted mid-run restores every output reset value on the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with PC register and IF/ID pipeline register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] pc_id,
  output logic [31:0] pc4_id,
  output logic [31:0] instr_id,
  output logic        valid_id
);

  // Fetch PC and IF/ID contents; every output comes straight from these registers.
  logic [31:0] r_pc;
  logic [31:0] r_pc_id;
  logic [31:0] r_pc4_id;
  logic [31:0] r_instr_id;
  logic        r_valid_id;

  // Sequential fall-through address; wraps modulo 2^32 by construction.
  logic [31:0] w_pc_plus4;
  // Redirect target with the low bits cleared so the PC can never go misaligned.
  logic [31:0] w_redirect_aligned;

  assign w_pc_plus4         = r_pc + 32'd4;
  assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};

  // PC and IF/ID update: reset, then redirect, then stall, then memory wait, then advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_pc_id    <= 32'h0000_0000;
      r_pc4_id   <= 32'h0000_0000;
      r_instr_id <= NOP;
      r_valid_id <= 1'b0;
    end else if (redirect) begin
      // Wrong-path fetch is dropped even if the pipeline is stalled.
      r_pc       <= w_redirect_aligned;
      r_instr_id <= NOP;
      r_valid_id <= 1'b0;
    end else if (!en) begin
      // Load-use stall: re-present the ID instruction unchanged, no bubble.
      r_pc       <= r_pc;
      r_pc_id    <= r_pc_id;
      r_pc4_id   <= r_pc4_id;
      r_instr_id <= r_instr_id;
      r_valid_id <= r_valid_id;
    end else if (!imem_valid) begin
      // Memory wait: keep fetching the same PC and feed a bubble downstream.
      r_pc       <= r_pc;
      r_instr_id <= NOP;
      r_valid_id <= 1'b0;
    end else begin
      r_pc       <= w_pc_plus4;
      r_pc_id    <= r_pc;
      r_pc4_id   <= w_pc_plus4;
      r_instr_id <= imem_rdata;
      r_valid_id <= 1'b1;
    end
  end

  assign imem_addr = r_pc;
  assign pc_id     = r_pc_id;
  assign pc4_id    = r_pc4_id;
  assign instr_id  = r_instr_id;
  assign valid_id  = r_valid_id;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] pc_id;
  logic [31:0] pc4_id;
  logic [31:0] instr_id;
  logic        valid_id;

  int checks;
  int failures;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .pc_id(pc_id), .pc4_id(pc4_id), .instr_id(instr_id), .valid_id(valid_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return 32'hA500_0000 + a;
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  typedef struct {
    logic        rst;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_valid;
    logic [31:0] addr;
    logic [31:0] pc_id;
    logic [31:0] pc4_id;
    logic [31:0] instr;
    logic        valid;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc_id;
    logic [31:0] pc4_id;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic rd, input logic [31:0] rpc,
                              input logic iv, input logic [31:0] a, input logic [31:0] p,
                              input logic [31:0] p4, input logic [31:0] ins, input logic v);
    vec_t t;
    t.rst = r; t.en = e; t.redirect = rd; t.redirect_pc = rpc; t.imem_valid = iv;
    t.addr = a; t.pc_id = p; t.pc4_id = p4; t.instr = ins; t.valid = v;
    return t;
  endfunction

  // Drive one cycle of inputs, push the expectation, and compare after the edge.
  task automatic run_vec(input vec_t t, input int idx);
    exp_t e;
    exp_t got;
    rst = t.rst; en = t.en; redirect = t.redirect; redirect_pc = t.redirect_pc; imem_valid = t.imem_valid;
    e.addr = t.addr; e.pc_id = t.pc_id; e.pc4_id = t.pc4_id; e.instr = t.instr; e.valid = t.valid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", idx);
    end else begin
      got = sb.pop_front();
      chk($sformatf("v%0d imem_addr", idx), imem_addr, got.addr);
      chk($sformatf("v%0d pc_id", idx), pc_id, got.pc_id);
      chk($sformatf("v%0d pc4_id", idx), pc4_id, got.pc4_id);
      chk($sformatf("v%0d instr_id", idx), instr_id, got.instr);
      chk($sformatf("v%0d valid_id", idx), {31'b0, valid_id}, {31'b0, got.valid});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; en = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_valid = 1'b1;

    //            rst en rd rpc           iv addr          pc_id         pc4_id        instr                 v
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        NOP,                  0)); // reset
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h4,        32'h0,        32'h4,        mem_f(32'h0),         1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h8,        32'h4,        32'h8,        mem_f(32'h4),         1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hC,        32'h8,        32'hC,        mem_f(32'h8),         1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hC,        32'h8,        32'hC,        mem_f(32'h8),         1)); // load-use stall
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h10,       32'hC,        32'h10,       mem_f(32'hC),         1));
    vecs.push_back(mk(0, 1, 1, 32'h103,      1, 32'h100,      32'hC,        32'h10,       NOP,                  0)); // redirect
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h104,      32'h100,      32'h104,      mem_f(32'h100),       1));
    vecs.push_back(mk(0, 1, 1, 32'h22,       1, 32'h20,       32'h100,      32'h104,      NOP,                  0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h20,       32'h100,      32'h104,      NOP,                  0)); // wait 1
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h20,       32'h100,      32'h104,      NOP,                  0)); // wait 2
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h20,       32'h100,      32'h104,      NOP,                  0)); // wait 3
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h24,       32'h20,       32'h24,       mem_f(32'h20),        1));
    vecs.push_back(mk(0, 0, 1, 32'h40,       1, 32'h40,       32'h20,       32'h24,       NOP,                  0)); // redirect beats stall
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h44,       32'h40,       32'h44,       mem_f(32'h40),        1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h44,       32'h40,       32'h44,       mem_f(32'h40),        1)); // stall beats wait
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFF,1, 32'hFFFF_FFFC,32'h40,       32'h44,       NOP,                  0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h0,        32'hFFFF_FFFC,32'h0,        mem_f(32'hFFFF_FFFC), 1)); // wrap
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h4,        32'h0,        32'h4,        mem_f(32'h0),         1));
    vecs.push_back(mk(0, 1, 1, 32'h200,      0, 32'h200,      32'h0,        32'h4,        NOP,                  0)); // redirect beats wait
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h204,      32'h200,      32'h204,      mem_f(32'h200),       1));
    vecs.push_back(mk(1, 1, 1, 32'h300,      1, 32'h0,        32'h0,        32'h0,        NOP,                  0)); // mid-run reset
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h4,        32'h0,        32'h4,        mem_f(32'h0),         1));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Outputs must not follow control inputs between edges.
    en = 1'b0; redirect = 1'b1; redirect_pc = 32'h800; imem_valid = 1'b0;
    #2;
    chk("comb imem_addr", imem_addr, 32'h4);
    chk("comb instr_id", instr_id, mem_f(32'h0));
    chk("comb valid_id", {31'b0, valid_id}, 32'h1);
    @(posedge clk);
    #1;
    chk("post redirect imem_addr", imem_addr, 32'h800);
    chk("post redirect instr_id", instr_id, NOP);

    // Two-cycle stall then resume: instruction held two cycles, then next appears.
    redirect = 1'b0; en = 1'b1; imem_valid = 1'b1;
    @(posedge clk); #1;
    chk("seq fetch instr", instr_id, mem_f(32'h800));
    en = 1'b0;
    @(posedge clk); #1;
    chk("seq stall1 instr", instr_id, mem_f(32'h800));
    chk("seq stall1 addr", imem_addr, 32'h804);
    @(posedge clk); #1;
    chk("seq stall2 instr", instr_id, mem_f(32'h800));
    chk("seq stall2 addr", imem_addr, 32'h804);
    en = 1'b1;
    @(posedge clk); #1;
    chk("seq resume instr", instr_id, mem_f(32'h804));
    chk("seq resume pc_id", pc_id, 32'h804);
    chk("seq resume pc4_id", pc4_id, 32'h808);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
